flag_save_stack: RTL and testbench

- LIFO of 4-bit status flags, directly upstream of the status register.
- On interrupt entry it captures the current flags.
- On RTI it pops the saved flags and drives the status register's saved-status input together with the RESTORE flag-op for exactly one cycle.
- Supports nested interrupts up to DEPTH levels.

---
 rtl/flag_save_stack_pkg.sv | 27 ++
 rtl/flag_lifo_mem.sv | 33 +++
 rtl/flag_save_stack.sv | 165 ++++++++++++++++
 tb/tb_flag_save_stack.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/flag_save_stack_pkg.sv
// Shared definitions for the flag save stack: flag bit positions,
// status-register flag-op codes and the controller state encoding.
package flag_save_stack_pkg;

    // Flag bit positions within the flag vector
    localparam int unsigned FLAG_Z = 0;
    localparam int unsigned FLAG_N = 1;
    localparam int unsigned FLAG_C = 2;
    localparam int unsigned FLAG_D = 3;

    // Default geometry
    localparam int unsigned FLAG_W_DEF = 4;
    localparam int unsigned DEPTH_DEF  = 4;

    // Flag-op codes understood by the status register's flag control
    localparam logic [1:0] OP_UPDATE  = 2'b00;
    localparam logic [1:0] OP_CLR_C   = 2'b01;
    localparam logic [1:0] OP_RESTORE = 2'b10;
    localparam logic [1:0] OP_SET_C   = 2'b11;

    // Controller states
    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_RESTORE = 1'b1
    } state_e;

endpackage

// File: rtl/flag_lifo_mem.sv
// Storage array for the flag save stack.
// Ports:
//   clk       - system clock, rising edge
//   i_we      - write enable
//   i_waddr   - write index
//   i_wdata   - flag vector to store
//   i_raddr   - read index
//   o_rdata   - flag vector at i_raddr (combinational read)
module flag_lifo_mem #(
    parameter int unsigned FLAG_W = 4,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = 2
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [FLAG_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [FLAG_W-1:0] o_rdata
);

    logic [FLAG_W-1:0] r_mem [DEPTH];

    // Contents are don't-care after reset, so the array carries no reset
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/flag_save_stack.sv
// LIFO of status flags saved on interrupt entry and restored on RTI.
// A restore drives saved_flags with flag_op=RESTORE for one cycle.
// Ports:
//   clk, reset        - clock, async active-high reset
//   stall             - freeze all state, ignore requests
//   save_req          - push cur_flags
//   restore_req       - pop top entry and strobe it out
//   cur_flags         - live flags from the status register
//   saved_flags       - registered value being restored
//   flag_op           - RESTORE while restore_valid, else UPDATE
//   restore_valid     - status register loads saved_flags this cycle
//   depth_cnt         - number of stored entries
//   full, empty       - depth_cnt at DEPTH / zero
//   overflow_err      - sticky, save while full
//   underflow_err     - sticky, restore while empty
module flag_save_stack
    import flag_save_stack_pkg::*;
#(
    parameter int unsigned FLAG_W = FLAG_W_DEF,
    parameter int unsigned DEPTH  = DEPTH_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   stall,
    input  logic                   save_req,
    input  logic                   restore_req,
    input  logic [FLAG_W-1:0]      cur_flags,
    output logic [FLAG_W-1:0]      saved_flags,
    output logic [1:0]             flag_op,
    output logic                   restore_valid,
    output logic [$clog2(DEPTH):0] depth_cnt,
    output logic                   full,
    output logic                   empty,
    output logic                   overflow_err,
    output logic                   underflow_err
);

    localparam int unsigned ADDR_W  = $clog2(DEPTH);
    localparam int unsigned DEPTH_W = ADDR_W + 1;

    state_e             r_state;
    state_e             w_state_nxt;
    logic [DEPTH_W-1:0] r_depth;
    logic [DEPTH_W-1:0] w_depth_nxt;
    logic               r_pending;
    logic               w_pending_nxt;
    logic [FLAG_W-1:0]  r_saved;
    logic [FLAG_W-1:0]  w_saved_nxt;
    logic               r_ovf;
    logic               w_ovf_nxt;
    logic               r_unf;
    logic               w_unf_nxt;

    logic               w_full;
    logic               w_empty;
    logic               w_we;
    logic [ADDR_W-1:0]  w_waddr;
    logic [ADDR_W-1:0]  w_raddr;
    logic [FLAG_W-1:0]  w_rdata;

    assign w_full  = (r_depth == DEPTH_W'(DEPTH));
    assign w_empty = (r_depth == '0);
    // Push lands at the first free slot; in RESTORE that is the slot just popped
    assign w_waddr = ADDR_W'(r_depth);
    assign w_raddr = ADDR_W'(r_depth - DEPTH_W'(1));

    flag_lifo_mem #(
        .FLAG_W (FLAG_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (cur_flags),
        .i_raddr (w_raddr),
        .o_rdata (w_rdata)
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_depth   <= '0;
            r_pending <= 1'b0;
            r_saved   <= '0;
            r_ovf     <= 1'b0;
            r_unf     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_depth   <= w_depth_nxt;
            r_pending <= w_pending_nxt;
            r_saved   <= w_saved_nxt;
            r_ovf     <= w_ovf_nxt;
            r_unf     <= w_unf_nxt;
        end
    end

    // Next-state and stack control
    always_comb begin
        w_state_nxt   = r_state;
        w_depth_nxt   = r_depth;
        w_pending_nxt = r_pending;
        w_saved_nxt   = r_saved;
        w_ovf_nxt     = r_ovf;
        w_unf_nxt     = r_unf;
        w_we          = 1'b0;

        if (!stall) begin
            case (r_state)
                ST_IDLE: begin
                    if (save_req) begin
                        // Save has priority; a coincident restore is deferred
                        if (!w_full) begin
                            w_we        = 1'b1;
                            w_depth_nxt = r_depth + DEPTH_W'(1);
                        end else begin
                            w_ovf_nxt = 1'b1;
                        end
                        if (restore_req) begin
                            w_pending_nxt = 1'b1;
                        end
                    end else if (restore_req || r_pending) begin
                        w_pending_nxt = 1'b0;
                        if (!w_empty) begin
                            w_saved_nxt = w_rdata;
                            w_depth_nxt = r_depth - DEPTH_W'(1);
                            w_state_nxt = ST_RESTORE;
                        end else begin
                            w_unf_nxt = 1'b1;
                        end
                    end
                end
                ST_RESTORE: begin
                    w_state_nxt = ST_IDLE;
                    if (save_req) begin
                        if (!w_full) begin
                            w_we        = 1'b1;
                            w_depth_nxt = r_depth + DEPTH_W'(1);
                        end else begin
                            w_ovf_nxt = 1'b1;
                        end
                    end
                    if (restore_req) begin
                        w_pending_nxt = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // Outputs decoded from registered state only
    assign saved_flags   = r_saved;
    assign restore_valid = (r_state == ST_RESTORE);
    assign flag_op       = (r_state == ST_RESTORE) ? OP_RESTORE : OP_UPDATE;
    assign depth_cnt     = r_depth;
    assign full          = w_full;
    assign empty         = w_empty;
    assign overflow_err  = r_ovf;
    assign underflow_err = r_unf;

endmodule

// File: tb/tb_flag_save_stack.sv
// Self-checking bench for flag_save_stack: directed scenarios followed by
// randomized traffic, all compared against a queue-based reference model.
module tb_flag_save_stack;

    localparam int unsigned FLAG_W = 4;
    localparam int unsigned DEPTH  = 4;

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   stall;
    logic                   save_req;
    logic                   restore_req;
    logic [FLAG_W-1:0]      cur_flags;
    logic [FLAG_W-1:0]      saved_flags;
    logic [1:0]             flag_op;
    logic                   restore_valid;
    logic [$clog2(DEPTH):0] depth_cnt;
    logic                   full;
    logic                   empty;
    logic                   overflow_err;
    logic                   underflow_err;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    // Reference model state
    logic [FLAG_W-1:0] m_stack[$];
    bit                m_strobe;
    bit                m_pend;
    bit                m_ovf;
    bit                m_unf;
    logic [FLAG_W-1:0] m_saved;

    flag_save_stack #(.FLAG_W(FLAG_W), .DEPTH(DEPTH)) dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .save_req      (save_req),
        .restore_req   (restore_req),
        .cur_flags     (cur_flags),
        .saved_flags   (saved_flags),
        .flag_op       (flag_op),
        .restore_valid (restore_valid),
        .depth_cnt     (depth_cnt),
        .full          (full),
        .empty         (empty),
        .overflow_err  (overflow_err),
        .underflow_err (underflow_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_stack.delete();
        m_strobe = 0;
        m_pend   = 0;
        m_ovf    = 0;
        m_unf    = 0;
        m_saved  = '0;
    endtask

    task automatic model_push(input logic [FLAG_W-1:0] f);
        if (m_stack.size() < DEPTH) m_stack.push_back(f);
        else m_ovf = 1;
    endtask

    // One clock of the reference behaviour, given the inputs seen at the edge
    task automatic model_clock(input bit s, input bit r, input logic [FLAG_W-1:0] f);
        if (m_strobe) begin
            m_strobe = 0;
            if (s) model_push(f);
            if (r) m_pend = 1;
        end else if (s) begin
            model_push(f);
            if (r) m_pend = 1;
        end else if (r || m_pend) begin
            m_pend = 0;
            if (m_stack.size() > 0) begin
                m_saved  = m_stack.pop_back();
                m_strobe = 1;
            end else begin
                m_unf = 1;
            end
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".depth"}, 32'(depth_cnt), 32'(m_stack.size()));
        check({tag, ".full"}, 32'(full), 32'(m_stack.size() == DEPTH));
        check({tag, ".empty"}, 32'(empty), 32'(m_stack.size() == 0));
        check({tag, ".valid"}, 32'(restore_valid), 32'(m_strobe));
        check({tag, ".op"}, 32'(flag_op), m_strobe ? 32'd2 : 32'd0);
        check({tag, ".saved"}, 32'(saved_flags), 32'(m_saved));
        check({tag, ".ovf"}, 32'(overflow_err), 32'(m_ovf));
        check({tag, ".unf"}, 32'(underflow_err), 32'(m_unf));
    endtask

    // Apply inputs for one cycle, advance model, check #1 after the edge
    task automatic step(input string tag, input bit s, input bit r, input bit st,
                        input logic [FLAG_W-1:0] f);
        save_req    = s;
        restore_req = r;
        stall       = st;
        cur_flags   = f;
        @(posedge clk);
        if (reset) model_reset();
        else if (!st) model_clock(s, r, f);
        #1;
        check_all(tag);
    endtask

    initial begin
        reset       = 1'b1;
        stall       = 1'b0;
        save_req    = 1'b0;
        restore_req = 1'b0;
        cur_flags   = '0;
        model_reset();
        #2;
        check_all("rst_async");
        step("rst", 0, 0, 0, 4'h0);
        reset = 1'b0;
        step("idle", 0, 0, 0, 4'h0);

        // Single save and restore
        step("s1_push", 1, 0, 0, 4'b1111);
        check("s1_depth1", 32'(depth_cnt), 32'd1);
        step("s1_pop", 0, 1, 0, 4'h0);
        check("s1_strobe_saved", 32'(saved_flags), 32'hF);
        check("s1_strobe_op", 32'(flag_op), 32'h2);
        step("s1_after", 0, 0, 0, 4'h0);
        check("s1_strobe_drop", 32'(restore_valid), 32'd0);

        // Nested saves return in reverse order
        step("n_push0", 1, 0, 0, 4'b1010);
        step("n_push1", 1, 0, 0, 4'b0101);
        step("n_push2", 1, 0, 0, 4'b0011);
        step("n_pop0", 0, 1, 0, 4'h0);
        check("n_first", 32'(saved_flags), 32'h3);
        step("n_gap0", 0, 0, 0, 4'h0);
        step("n_pop1", 0, 1, 0, 4'h0);
        check("n_second", 32'(saved_flags), 32'h5);
        step("n_gap1", 0, 0, 0, 4'h0);
        step("n_pop2", 0, 1, 0, 4'h0);
        check("n_third", 32'(saved_flags), 32'hA);
        step("n_end", 0, 0, 0, 4'h0);
        check("n_empty", 32'(empty), 32'd1);

        // Overflow at DEPTH, then drain and underflow
        step("f_push0", 1, 0, 0, 4'h1);
        step("f_push1", 1, 0, 0, 4'h2);
        step("f_push2", 1, 0, 0, 4'h4);
        step("f_push3", 1, 0, 0, 4'h9);
        step("f_push4", 1, 0, 0, 4'hE);
        check("f_ovf", 32'(overflow_err), 32'd1);
        check("f_depth", 32'(depth_cnt), 32'd4);
        step("f_pop_top", 0, 1, 0, 4'h0);
        check("f_top", 32'(saved_flags), 32'h9);
        for (int i = 0; i < 3; i++) begin
            step("f_gap", 0, 0, 0, 4'h0);
            step("f_pop", 0, 1, 0, 4'h0);
        end
        step("f_drained", 0, 0, 0, 4'h0);
        step("u_pop", 0, 1, 0, 4'h0);
        check("u_unf", 32'(underflow_err), 32'd1);
        check("u_nostrobe", 32'(restore_valid), 32'd0);
        step("u_idle", 0, 0, 0, 4'h0);

        // Same-cycle save and restore: the just-pushed entry is popped
        step("c_push", 1, 0, 0, 4'b0110);
        step("c_both", 1, 1, 0, 4'b1000);
        check("c_depth2", 32'(depth_cnt), 32'd2);
        step("c_pend", 0, 0, 0, 4'h0);
        check("c_saved", 32'(saved_flags), 32'h8);
        check("c_depth1", 32'(depth_cnt), 32'd1);
        step("c_idle", 0, 0, 0, 4'h0);

        // Stall holds the restore strobe
        step("st_pop", 0, 1, 0, 4'h0);
        for (int i = 0; i < 3; i++) begin
            step("st_hold", 1, 1, 1, 4'h7);
            check("st_valid", 32'(restore_valid), 32'd1);
            check("st_depth", 32'(depth_cnt), 32'd0);
        end
        step("st_release", 0, 0, 0, 4'h0);
        check("st_drop", 32'(restore_valid), 32'd0);

        // Async reset in the middle of a restore
        step("r_push", 1, 0, 0, 4'hC);
        step("r_pop", 0, 1, 0, 4'h0);
        check("r_inrestore", 32'(restore_valid), 32'd1);
        #3;
        reset = 1'b1;
        #1;
        model_reset();
        check_all("r_async");
        check("r_valid0", 32'(restore_valid), 32'd0);
        check("r_unf0", 32'(underflow_err), 32'd0);
        step("r_held", 0, 0, 0, 4'h0);
        reset = 1'b0;
        step("r_idle", 0, 0, 0, 4'h0);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            if (i % 150 == 149) reset = 1'b1;
            step("rnd", ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 5) == 0), 4'($urandom));
            reset = 1'b0;
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
